// File: rtl/tiny_fpga_cfg_loader.sv
// Configuration sequencer for the tiny_fpga_2x2 fabric: serializes host words
// into bitstream beats, then waits for cfg_ready (with timeout) before enabling run.
module tiny_fpga_cfg_loader #(
  parameter int HOST_WIDTH           = 8,
  parameter int BITSTREAM_DATA_WIDTH = 1,
  parameter int BITSTREAM_BEATS      = 64,
  parameter int TIMEOUT_CYCLES       = 255
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            host_valid,
  output logic                            host_ready,
  input  logic [HOST_WIDTH-1:0]           host_data,
  output logic                            cfg,
  output logic                            bs_tvalid,
  input  logic                            bs_tready,
  output logic [BITSTREAM_DATA_WIDTH-1:0] bs_tdata,
  output logic                            bs_tlast,
  input  logic                            cfg_ready,
  output logic                            run,
  output logic                            busy,
  output logic                            done,
  output logic                            error
);

  localparam int BEATS_PER_WORD = HOST_WIDTH / BITSTREAM_DATA_WIDTH;
  localparam int BEAT_W         = $clog2(BITSTREAM_BEATS) + 1;
  localparam int SUB_W          = $clog2(BEATS_PER_WORD) + 1;
  localparam int TO_W           = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BITSTREAM_BEATS - 1);
  localparam logic [SUB_W-1:0]  LAST_SUB  = SUB_W'(BEATS_PER_WORD - 1);
  localparam logic [TO_W-1:0]   TO_LIMIT  = TO_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WAIT_DONE,
    S_RUN,
    S_ERROR
  } state_t;

  state_t                  state_reg;
  logic [HOST_WIDTH-1:0]   shift_reg;
  logic [BEAT_W-1:0]       beat_cnt_reg;
  logic [SUB_W-1:0]        sub_cnt_reg;
  logic [TO_W-1:0]         to_cnt_reg;
  logic [TO_W-1:0]         to_cnt_next;
  logic                    word_fire;
  logic                    beat_fire;

  assign word_fire   = host_valid && host_ready;
  assign beat_fire   = bs_tvalid && bs_tready;
  assign to_cnt_next = to_cnt_reg + TO_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      shift_reg    <= '0;
      beat_cnt_reg <= '0;
      sub_cnt_reg  <= '0;
      to_cnt_reg   <= '0;
      host_ready   <= 1'b0;
      cfg          <= 1'b0;
      bs_tvalid    <= 1'b0;
      bs_tdata     <= '0;
      bs_tlast     <= 1'b0;
      run          <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE, S_RUN, S_ERROR: begin
          if (start) begin
            state_reg    <= S_LOAD;
            beat_cnt_reg <= '0;
            sub_cnt_reg  <= '0;
            to_cnt_reg   <= '0;
            host_ready   <= 1'b1;
            cfg          <= 1'b1;
            busy         <= 1'b1;
            bs_tvalid    <= 1'b0;
            bs_tlast     <= 1'b0;
            run          <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
          end
        end

        S_LOAD: begin
          // host_ready is only high while the buffer is empty, so a word
          // capture and a beat handshake can never coincide.
          if (word_fire) begin
            host_ready  <= 1'b0;
            bs_tvalid   <= 1'b1;
            bs_tdata    <= host_data[BITSTREAM_DATA_WIDTH-1:0];
            shift_reg   <= host_data >> BITSTREAM_DATA_WIDTH;
            sub_cnt_reg <= '0;
            bs_tlast    <= (beat_cnt_reg == LAST_BEAT);
          end else if (beat_fire) begin
            beat_cnt_reg <= beat_cnt_reg + BEAT_W'(1);
            if (bs_tlast) begin
              bs_tvalid  <= 1'b0;
              bs_tlast   <= 1'b0;
              host_ready <= 1'b0;
              to_cnt_reg <= '0;
              state_reg  <= S_WAIT_DONE;
            end else if (sub_cnt_reg == LAST_SUB) begin
              bs_tvalid  <= 1'b0;
              host_ready <= 1'b1;
            end else begin
              bs_tdata    <= shift_reg[BITSTREAM_DATA_WIDTH-1:0];
              shift_reg   <= shift_reg >> BITSTREAM_DATA_WIDTH;
              sub_cnt_reg <= sub_cnt_reg + SUB_W'(1);
              bs_tlast    <= ((beat_cnt_reg + BEAT_W'(1)) == LAST_BEAT);
            end
          end
        end

        S_WAIT_DONE: begin
          // The entry cycle counts as the first waiting cycle; cfg_ready is
          // checked first so it wins on the final waiting cycle.
          if (cfg_ready) begin
            state_reg <= S_RUN;
            cfg       <= 1'b0;
            busy      <= 1'b0;
            run       <= 1'b1;
            done      <= 1'b1;
          end else if (to_cnt_next == TO_LIMIT) begin
            state_reg  <= S_ERROR;
            to_cnt_reg <= to_cnt_next;
            cfg        <= 1'b0;
            busy       <= 1'b0;
            run        <= 1'b0;
            error      <= 1'b1;
          end else begin
            to_cnt_reg <= to_cnt_next;
          end
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tiny_fpga_cfg_loader.sv
// Directed self-checking bench for tiny_fpga_cfg_loader with default parameters.
module tb_tiny_fpga_cfg_loader;

  logic       clk = 1'b0;
  logic       rst, start, host_valid, host_ready;
  logic [7:0] host_data;
  logic       cfg, bs_tvalid, bs_tready, bs_tlast, cfg_ready;
  logic [0:0] bs_tdata;
  logic       run, busy, done, error;

  int checks = 0;
  int errors = 0;

  logic [7:0] words [8];
  logic [1:0] beat_q [$];
  int         stab_err = 0;
  int         hr_err = 0;
  logic       prev_stall = 1'b0;
  logic [0:0] prev_data = 1'b0;

  always #5 clk = ~clk;

  tiny_fpga_cfg_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .host_valid(host_valid), .host_ready(host_ready), .host_data(host_data),
    .cfg(cfg), .bs_tvalid(bs_tvalid), .bs_tready(bs_tready),
    .bs_tdata(bs_tdata), .bs_tlast(bs_tlast), .cfg_ready(cfg_ready),
    .run(run), .busy(busy), .done(done), .error(error)
  );

  // Beat recorder plus AXI stability and buffer-occupancy watchers.
  always @(posedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (bs_tvalid && bs_tready) beat_q.push_back({bs_tlast, bs_tdata});
      if (prev_stall && (!bs_tvalid || bs_tdata !== prev_data)) stab_err <= stab_err + 1;
      if (host_ready && bs_tvalid) hr_err <= hr_err + 1;
      prev_stall <= bs_tvalid && !bs_tready;
      prev_data  <= bs_tdata;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_words(input logic [7:0] base);
    for (int j = 0; j < 8; j++) words[j] = base + 8'(j);
  endtask

  task automatic beat_errs(output int n);
    logic [7:0] w;
    logic [1:0] exp_b;
    n = 0;
    if (beat_q.size() != 64) begin
      n = 1000 + beat_q.size();
    end else begin
      for (int b = 0; b < 64; b++) begin
        w = words[b / 8];
        exp_b = {(b == 63), w[b % 8]};
        if (beat_q[b] !== exp_b) n++;
      end
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Drives the host side until stop_at beats have been accepted.
  task automatic do_load(input int bp, input int starve, input int start_mid,
                         input int stop_at, output int cfg_bad,
                         output int starve_q, output logic starve_tv);
    int   idx;
    int   cyc;
    int   starve_left;
    logic hs;
    idx = 0; cyc = 0; starve_left = 20; cfg_bad = 0;
    starve_q = -1; starve_tv = 1'bx;
    beat_q.delete();
    while (beat_q.size() < stop_at && cyc < 3000) begin
      if (starve != 0 && idx == 4 && starve_left > 0) begin
        host_valid = 1'b0;
        starve_left--;
        if (starve_left == 0) begin
          starve_q  = beat_q.size();
          starve_tv = bs_tvalid;
        end
      end else begin
        host_valid = (idx < 8);
      end
      host_data = words[(idx < 8) ? idx : 7];
      bs_tready = (bp != 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
      start     = (start_mid != 0 && cyc == 20);
      if (!cfg || !busy) cfg_bad++;
      hs = host_valid && host_ready;
      tick();
      if (hs) idx++;
      cyc++;
    end
    host_valid = 1'b0;
    bs_tready  = 1'b0;
    start      = 1'b0;
  endtask

  task automatic finish_run();
    cfg_ready = 1'b1;
    tick();
    cfg_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; host_valid = 0; host_data = 0; bs_tready = 0; cfg_ready = 0;
    tick(); tick();
    checks++;
    if ({host_ready, cfg, bs_tvalid, bs_tdata, bs_tlast, run, busy, done, error} !== 9'b0) begin
      errors++;
      $display("FAIL reset_values: got %b expected 000000000",
               {host_ready, cfg, bs_tvalid, bs_tdata, bs_tlast, run, busy, done, error});
    end
    rst = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_nominal();
    int cb, sq, n;
    logic stv;
    set_words(8'h01);
    do_start();
    checks++;
    if ({cfg, busy, host_ready, run, done} !== 5'b11100) begin
      errors++;
      $display("FAIL nominal_start: cfg,busy,host_ready,run,done=%b expected 11100",
               {cfg, busy, host_ready, run, done});
    end
    do_load(0, 0, 0, 64, cb, sq, stv);
    beat_errs(n);
    checks++;
    if (n !== 0) begin errors++; $display("FAIL nominal_beats: %0d bad beats expected 0", n); end
    checks++;
    if (cb !== 0) begin errors++; $display("FAIL nominal_cfg_held: %0d cycles cfg/busy low expected 0", cb); end
    checks++;
    if ({busy, cfg, bs_tvalid, host_ready} !== 4'b1100) begin
      errors++;
      $display("FAIL nominal_wait_entry: busy,cfg,tvalid,host_ready=%b expected 1100",
               {busy, cfg, bs_tvalid, host_ready});
    end
    host_valid = 1'b1;
    tick(); tick(); tick();
    host_valid = 1'b0;
    finish_run();
    checks++;
    if ({run, done, cfg, busy, error, host_ready} !== 6'b110000) begin
      errors++;
      $display("FAIL nominal_run: run,done,cfg,busy,error,host_ready=%b expected 110000",
               {run, done, cfg, busy, error, host_ready});
    end
    $display("test_nominal done: %0d beats", beat_q.size());
  endtask

  task automatic test_backpressure();
    int cb, sq, n, s0, h0;
    logic stv;
    set_words(8'h5A);
    do_start();
    checks++;
    if ({run, done, cfg} !== 3'b001) begin
      errors++;
      $display("FAIL restart_from_run: run,done,cfg=%b expected 001", {run, done, cfg});
    end
    s0 = stab_err; h0 = hr_err;
    do_load(1, 0, 0, 64, cb, sq, stv);
    beat_errs(n);
    checks++;
    if (n !== 0) begin errors++; $display("FAIL bp_beats: %0d bad beats expected 0", n); end
    checks++;
    if (stab_err - s0 !== 0) begin errors++; $display("FAIL bp_stable: %0d violations expected 0", stab_err - s0); end
    checks++;
    if (hr_err - h0 !== 0) begin errors++; $display("FAIL bp_host_ready: %0d violations expected 0", hr_err - h0); end
    finish_run();
    $display("test_backpressure done: %0d beats", beat_q.size());
  endtask

  task automatic test_starvation();
    int cb, sq, n;
    logic stv;
    set_words(8'hE1);
    do_start();
    do_load(0, 1, 0, 64, cb, sq, stv);
    checks++;
    if (sq !== 32) begin errors++; $display("FAIL starve_frozen: beats=%0d expected 32", sq); end
    checks++;
    if (stv !== 1'b0) begin errors++; $display("FAIL starve_tvalid: got %b expected 0", stv); end
    beat_errs(n);
    checks++;
    if (n !== 0) begin errors++; $display("FAIL starve_beats: %0d bad beats expected 0", n); end
    finish_run();
    checks++;
    if ({run, done} !== 2'b11) begin errors++; $display("FAIL starve_run: run,done=%b expected 11", {run, done}); end
    $display("test_starvation done: %0d beats", beat_q.size());
  endtask

  task automatic test_timeout();
    int cb, sq, n, early;
    logic stv;
    set_words(8'h10);
    do_start();
    do_load(0, 0, 0, 64, cb, sq, stv);
    early = 0;
    for (int k = 0; k < 254; k++) begin
      tick();
      if (error || !cfg) early++;
    end
    checks++;
    if (early !== 0) begin errors++; $display("FAIL timeout_early: %0d early cycles expected 0", early); end
    tick();
    checks++;
    if ({error, cfg, run, busy, done} !== 5'b10000) begin
      errors++;
      $display("FAIL timeout_error: error,cfg,run,busy,done=%b expected 10000",
               {error, cfg, run, busy, done});
    end
    set_words(8'h3C);
    do_start();
    checks++;
    if ({error, cfg, busy} !== 3'b011) begin
      errors++;
      $display("FAIL timeout_restart: error,cfg,busy=%b expected 011", {error, cfg, busy});
    end
    do_load(0, 0, 0, 64, cb, sq, stv);
    beat_errs(n);
    checks++;
    if (n !== 0) begin errors++; $display("FAIL timeout_reload_beats: %0d bad beats expected 0", n); end
    finish_run();
    checks++;
    if ({run, error} !== 2'b10) begin errors++; $display("FAIL timeout_reload_run: run,error=%b expected 10", {run, error}); end
    $display("test_timeout done");
  endtask

  task automatic test_boundary();
    int cb, sq, n;
    logic stv;
    set_words(8'h77);
    do_start();
    do_load(0, 0, 1, 64, cb, sq, stv);
    beat_errs(n);
    checks++;
    if (n !== 0) begin errors++; $display("FAIL start_in_load_beats: %0d bad beats expected 0", n); end
    for (int k = 0; k < 254; k++) tick();
    finish_run();
    checks++;
    if ({run, done, error, cfg} !== 4'b1100) begin
      errors++;
      $display("FAIL timeout_cycle_ready: run,done,error,cfg=%b expected 1100", {run, done, error, cfg});
    end
    $display("test_boundary done");
  endtask

  task automatic test_reset_mid();
    int cb, sq, n;
    logic stv;
    set_words(8'h96);
    do_start();
    do_load(0, 0, 0, 31, cb, sq, stv);
    checks++;
    if (beat_q.size() !== 31) begin errors++; $display("FAIL reset_mid_progress: beats=%0d expected 31", beat_q.size()); end
    rst = 1'b1;
    tick();
    checks++;
    if ({host_ready, cfg, bs_tvalid, bs_tdata, bs_tlast, run, busy, done, error} !== 9'b0) begin
      errors++;
      $display("FAIL reset_mid_values: got %b expected 000000000",
               {host_ready, cfg, bs_tvalid, bs_tdata, bs_tlast, run, busy, done, error});
    end
    rst = 1'b0;
    tick();
    set_words(8'hC3);
    do_start();
    do_load(0, 0, 0, 64, cb, sq, stv);
    beat_errs(n);
    checks++;
    if (n !== 0) begin errors++; $display("FAIL reset_mid_reload: %0d bad beats expected 0", n); end
    finish_run();
    $display("test_reset_mid done");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_starvation();
    test_timeout();
    test_boundary();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tiny_fpga_cfg_loader.md
Name: tiny_fpga_cfg_loader

Overview:
Configuration sequencer placed in front of the tiny_fpga_2x2 fabric. Accepts the bitstream from a host as HOST_WIDTH-bit words and serializes it into BITSTREAM_DATA_WIDTH-bit AXI-stream beats on the fabric's cfg_bitstream slave port. It owns the fabric's cfg and run controls: it raises cfg for the load, waits for cfg_ready, then enables run. It also reports load status and timeout errors to the host.

Parameters:
HOST_WIDTH, 8, host word width; must be an integer multiple of BITSTREAM_DATA_WIDTH
BITSTREAM_DATA_WIDTH, 1, fabric bitstream beat width
BITSTREAM_BEATS, 64, total beats in one full bitstream; must be a multiple of HOST_WIDTH/BITSTREAM_DATA_WIDTH
TIMEOUT_CYCLES, 255, maximum cycles to wait for cfg_ready after the last beat

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  one-cycle pulse: begin a new configuration
host_valid  in  1  host word valid
host_ready  out  1  loader accepts host word
host_data  in  HOST_WIDTH  host word; beats taken LSB-first
cfg  out  1  fabric configuration-mode enable
bs_tvalid  out  1  bitstream beat valid (to cfg_bitstream)
bs_tready  in  1  fabric accepts beat
bs_tdata  out  BITSTREAM_DATA_WIDTH  beat data
bs_tlast  out  1  final beat of the bitstream
cfg_ready  in  1  fabric reports configuration complete
run  out  1  fabric run enable
busy  out  1  high in LOAD or WAIT_DONE
done  out  1  high in RUN
error  out  1  high in ERROR (sticky until start or rst)

Behaviour:
- All outputs are registered. Reset values: host_ready=0, cfg=0, bs_tvalid=0, bs_tdata=0, bs_tlast=0, run=0, busy=0, done=0, error=0. State=IDLE, counters=0.
- States: IDLE, LOAD, WAIT_DONE, RUN, ERROR.
- IDLE, start=1: go to LOAD. Next cycle cfg=1, busy=1, host_ready=1, beat counter=0.
- IDLE, RUN or ERROR, start=1: restart. Go to LOAD, drop run/done/error the next cycle.
- start during LOAD or WAIT_DONE is ignored.
- LOAD uses a one-word shift buffer:
  - host_ready=1 only while the buffer is empty.
  - A word is captured on host_valid&&host_ready.
  - The next cycle presents beat 0 on bs_tdata with bs_tvalid=1. Each bs_tvalid&&bs_tready shifts right by BITSTREAM_DATA_WIDTH.
  - After the last beat of a word is accepted, host_ready rises the same cycle (registered: visible next cycle). Minimum cost is 1 bubble per host word.
  - bs_tdata and bs_tvalid are held stable while bs_tvalid && !bs_tready (AXI rule).
  - bs_tvalid never depends on bs_tready.
- The beat counter counts accepted beats. bs_tlast=1 exactly on beat BITSTREAM_BEATS-1.
- Once the tlast beat is accepted: host_ready=0, bs_tvalid=0, go to WAIT_DONE, and the timeout counter clears. Extra host words are not accepted.
- WAIT_DONE, cfg stays 1:
  - cfg_ready=1 -> RUN. The next cycle has cfg=0, run=1, done=1, busy=0.
  - Timeout counter reaches TIMEOUT_CYCLES without cfg_ready -> ERROR (cfg=0, run=0, error=1).
  - If cfg_ready=1 on the same cycle the counter reaches TIMEOUT_CYCLES, RUN wins.
- cfg_ready in states other than WAIT_DONE is ignored.
- RUN: run=1 until start or rst.
- ERROR: all handshakes idle, error=1 until start or rst.
- rst mid-load: everything returns to reset values the next cycle. The partial word is discarded and the beat counter clears. Nothing resumes; the host must start again.
- Counter widths are $clog2 of their limits +1. No wrap-around is possible in normal operation.

Test Plan:
- Nominal load, defaults: start, then 8 host words 0x01..0x08 with bs_tready always 1 -> 64 beats, LSB-first (beat0=1, beats1-7=0, beat8=0, beat9=1, ...). bs_tlast only on beat 63, cfg=1 throughout. cfg_ready pulsed 3 cycles later -> run=1, done=1, cfg=0 the next cycle.
- Backpressure: bs_tready random 50% with host_valid always 1 -> bs_tdata/bs_tvalid stable while stalled, host_ready never high while the buffer holds data, and the beat sequence is identical to the nominal case.
- Host starvation: host_valid low for 20 cycles mid-load -> bs_tvalid=0, beat counter frozen, and the load completes correctly afterwards.
- Timeout: no cfg_ready after the last beat -> error=1 exactly TIMEOUT_CYCLES (255) cycles after WAIT_DONE entry, with cfg=0 and run=0. A following start clears error and reloads successfully.
- Boundary: cfg_ready on the timeout cycle -> RUN, error stays 0. start asserted during LOAD -> ignored, beat count unaffected.
- Reset mid-operation: rst after beat 30 -> all outputs at reset values the next cycle. A new start streams 64 fresh beats beginning at beat 0.
